// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - bus bundle between the data-memory arbiter and its clients
// Purpose: groups processor status, core/host request ports, the single-port
//  memory port and the arbiter state outputs.
// Signals:
//  status                          processor status (00 idle, 01 start, 10 running)
//  core_req/we/addr/wdata          core request, held until core_ack
//  core_ack/core_rdata             core completion pulse and read data
//  host_req/we/addr/wdata          host loader request, held until host_ack
//  host_ack/host_rdata             host completion pulse and read data
//  mem_en/we/addr/wdata/rdata      memory port
//  busy/owner                      arbiter busy, current owner (0 core, 1 host)
// Modports: slave = arbiter side, master = clients/memory side.
interface dm_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [1:0]        status;

    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_ack;
    logic [DATA_W-1:0] core_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  status,
        input  core_req, core_we, core_addr, core_wdata,
        output core_ack, core_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output status,
        output core_req, core_we, core_addr, core_wdata,
        input  core_ack, core_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - data-memory arbiter between processor core and host loader
// Purpose: shares the single-port data memory between the core (LOAD/STORE)
//  and the host image loader. One access in flight; default priority follows
//  processor status, and an aging counter per requester prevents starvation.
// Ports:
//  clk   in  rising-edge clock
//  rst   in  asynchronous reset, active-high
//  bus   dm_arbiter_if.slave: status, core_*/host_* request/ack ports,
//        mem_* memory port, busy, owner
module dm_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    dm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] AGE_MAX  = 4'(MAX_WAIT);
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        core_age_q, core_age_d;
    logic [3:0]        host_age_q, host_age_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              core_ack_q, core_ack_d;
    logic              host_ack_q, host_ack_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              pick_host;

    function automatic logic [3:0] sat_inc(input logic [3:0] age);
        return (age == AGE_MAX) ? age : age + 4'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        core_age_d   = core_age_q;
        host_age_d   = host_age_q;
        wait_cnt_d   = wait_cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        owner_d      = owner_q;
        core_ack_d   = 1'b0;
        host_ack_d   = 1'b0;
        core_rdata_d = core_rdata_q;
        host_rdata_d = host_rdata_q;
        pick_host    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A requester that has lost MAX_WAIT times in a row overrides
                // the status-based default; only one can be aged at a time
                // because the winner's counter is cleared on every grant.
                if (bus.core_req && bus.host_req) begin
                    if (core_age_q == AGE_MAX) begin
                        pick_host = 1'b0;
                    end else if (host_age_q == AGE_MAX) begin
                        pick_host = 1'b1;
                    end else begin
                        pick_host = (bus.status != 2'b10);
                    end
                end else begin
                    pick_host = bus.host_req;
                end

                // Age only while losing; grant or absent request clears it.
                core_age_d = (bus.core_req && pick_host)  ? sat_inc(core_age_q) : 4'd0;
                host_age_d = (bus.host_req && !pick_host) ? sat_inc(host_age_q) : 4'd0;

                if (bus.core_req || bus.host_req) begin
                    owner_d     = pick_host;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_host ? bus.host_we    : bus.core_we;
                    mem_addr_d  = pick_host ? bus.host_addr  : bus.core_addr;
                    mem_wdata_d = pick_host ? bus.host_wdata : bus.core_wdata;
                    state_d     = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (mem_we_q) begin
                    core_ack_d = !owner_q;
                    host_ack_d = owner_q;
                    state_d    = S_RESP;
                end else begin
                    wait_cnt_d = 2'd0;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                if (wait_cnt_q == LAT_LAST) begin
                    if (owner_q) begin
                        host_rdata_d = bus.mem_rdata;
                    end else begin
                        core_rdata_d = bus.mem_rdata;
                    end
                    core_ack_d = !owner_q;
                    host_ack_d = owner_q;
                    state_d    = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            core_age_q   <= 4'd0;
            host_age_q   <= 4'd0;
            wait_cnt_q   <= 2'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
            core_ack_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            core_age_q   <= core_age_d;
            host_age_q   <= host_age_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            core_ack_q   <= core_ack_d;
            host_ack_q   <= host_ack_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = busy_q;
    assign bus.core_ack   = core_ack_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.core_rdata = core_rdata_q;
    assign bus.host_rdata = host_rdata_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard bench for dm_arbiter
module tb_dm_arbiter;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;

    logic clk;
    logic rst;

    dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dm_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RD_LAT  (RD_LAT),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string why);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Memory device seen by the DUT.
    logic [7:0] dev_mem [0:65535];
    logic [7:0] rd_pipe [0:3];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) dev_mem[bus.mem_addr] <= bus.mem_wdata;
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? dev_mem[bus.mem_addr] : 8'hxx;
        for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    // Reference model: transaction-level view of arbitration and timing.
    typedef struct { int cyc; bit own; bit we; logic [15:0] addr; logic [7:0] data; } acc_t;
    typedef struct { int cyc; logic [7:0] data; } ack_t;

    acc_t exp_acc[$];
    ack_t exp_core[$];
    ack_t exp_host[$];
    bit   grant_log[$];

    logic [7:0] ref_mem [0:65535];
    int   cyc         = 0;
    int   m_free      = 0;
    int   m_core_wait = 0;
    int   m_host_wait = 0;
    logic [7:0] m_core_rd = 8'h00;
    logic [7:0] m_host_rd = 8'h00;
    bit   m_c, m_h, m_win, m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    ack_t m_ack;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_acc.delete();
            exp_core.delete();
            exp_host.delete();
            m_free      = 0;
            m_core_wait = 0;
            m_host_wait = 0;
            m_core_rd   = 8'h00;
            m_host_rd   = 8'h00;
        end else begin
            cyc = cyc + 1;
            if (cyc >= m_free) begin
                m_c   = bus.core_req;
                m_h   = bus.host_req;
                m_win = m_h;
                if (m_c && m_h) begin
                    if (m_core_wait >= MAX_WAIT)      m_win = 1'b0;
                    else if (m_host_wait >= MAX_WAIT) m_win = 1'b1;
                    else                              m_win = (bus.status != 2'b10);
                end
                if (m_c || m_h) begin
                    m_we   = m_win ? bus.host_we    : bus.core_we;
                    m_addr = m_win ? bus.host_addr  : bus.core_addr;
                    m_data = m_win ? bus.host_wdata : bus.core_wdata;
                    exp_acc.push_back('{cyc, m_win, m_we, m_addr, m_data});
                    if (m_we) begin
                        ref_mem[m_addr] = m_data;
                        m_ack  = '{cyc + 1, m_win ? m_host_rd : m_core_rd};
                        m_free = cyc + 3;
                    end else begin
                        if (m_win) m_host_rd = ref_mem[m_addr];
                        else       m_core_rd = ref_mem[m_addr];
                        m_ack  = '{cyc + 1 + RD_LAT, ref_mem[m_addr]};
                        m_free = cyc + 3 + RD_LAT;
                    end
                    if (m_win) exp_host.push_back(m_ack);
                    else       exp_core.push_back(m_ack);
                end
                m_core_wait = (m_c && m_win)  ? ((m_core_wait < MAX_WAIT) ? m_core_wait + 1 : MAX_WAIT) : 0;
                m_host_wait = (m_h && !m_win) ? ((m_host_wait < MAX_WAIT) ? m_host_wait + 1 : MAX_WAIT) : 0;
            end
        end
    end

    // Monitor: compares every DUT output event with the next expectation.
    acc_t ea;
    ack_t ek;
    int   host_ack_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_en) begin
                grant_log.push_back(bus.owner);
                if (exp_acc.size() == 0) begin
                    flag("mem_access", "unexpected mem_en");
                end else begin
                    ea = exp_acc.pop_front();
                    check("mem_access",
                          {cyc[15:0], bus.owner, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                          {ea.cyc[15:0], ea.own, ea.we, ea.addr, ea.data});
                    check("busy_in_access", {63'd0, bus.busy}, 64'd1);
                end
            end
            if (bus.core_ack) begin
                if (exp_core.size() == 0) begin
                    flag("core_ack", "unexpected core_ack");
                end else begin
                    ek = exp_core.pop_front();
                    check("core_ack", {cyc[15:0], bus.core_rdata}, {ek.cyc[15:0], ek.data});
                end
            end
            if (bus.host_ack) begin
                host_ack_cnt++;
                if (exp_host.size() == 0) begin
                    flag("host_ack", "unexpected host_ack");
                end else begin
                    ek = exp_host.pop_front();
                    check("host_ack", {cyc[15:0], bus.host_rdata}, {ek.cyc[15:0], ek.data});
                end
            end
        end
    end

    // Requester driver: call at a negedge; returns negedges until ack.
    task automatic issue_one(input bit side, input bit we, input logic [15:0] a,
                             input logic [7:0] d, input bit keep, output int lat);
        bit got;
        if (side) begin
            bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
        end else begin
            bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            got = side ? bus.host_ack : bus.core_ack;
        end
        if (!got) flag(side ? "host_timeout" : "core_timeout", "no ack within 400 cycles");
        if (!keep || !got) begin
            if (side) bus.host_req = 1'b0;
            else      bus.core_req = 1'b0;
        end
    endtask

    function automatic logic [15:0] addr_pick();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 31));
    endfunction

    task automatic issue(input bit side, input int n, input bit cont, input int max_gap);
        int  lat;
        bit  keep;
        for (int i = 0; i < n; i++) begin
            keep = cont && (i < n - 1);
            issue_one(side, 1'($urandom_range(0, 1)), addr_pick(), 8'($urandom), keep, lat);
            if (!keep) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic check_order(input string name, input bit [9:0] exp);
        bit [9:0] got;
        got = '0;
        check({name, "_count"}, 64'(grant_log.size()), 64'd10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++) got[9-i] = grant_log[i];
        check(name, {54'd0, got}, {54'd0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  lat, lat_c, t, cnt0;
    bit  rand_done;
    logic [7:0] v;

    initial begin
        rst = 1'b1;
        bus.status = 2'b00;
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            dev_mem[i] = v;
            ref_mem[i] = v;
        end
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.core_ack, bus.host_ack,
               bus.core_rdata, bus.host_rdata, bus.busy, bus.owner}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Core write, status running.
        bus.status = 2'b10;
        issue_one(1'b0, 1'b1, 16'h0010, 8'hA5, 1'b0, lat);
        check("write_ack_latency", 64'(lat), 64'd2);
        @(negedge clk);
        check("write_ack_one_cycle", {63'd0, bus.core_ack}, 64'd0);
        repeat (2) @(negedge clk);

        // Host read of the same word.
        bus.status = 2'b00;
        issue_one(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, lat);
        check("read_ack_latency", 64'(lat), 64'(2 + RD_LAT));
        check("host_rdata", {56'd0, bus.host_rdata}, 64'hA5);
        check("core_rdata_untouched", {56'd0, bus.core_rdata}, 64'd0);
        repeat (3) @(negedge clk);
        check("host_rdata_held", {56'd0, bus.host_rdata}, 64'hA5);

        // Reset during the WAIT phase of a host read.
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h0010;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.mem_en && t < 20);
        if (!bus.mem_en) flag("rst_read_grant", "host read never granted");
        bus.host_req = 1'b0;
        cnt0 = host_ack_cnt;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mem_en", {63'd0, bus.mem_en}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_host_ack", {63'd0, bus.host_ack}, 64'd0);
        check("rst_host_rdata", {56'd0, bus.host_rdata}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_no_ack", 64'(host_ack_cnt - cnt0), 64'd0);

        // Both requesting continuously while running: core x4, host x1.
        grant_log.delete();
        bus.status = 2'b10;
        fork
            issue(1'b0, 8, 1'b1, 0);
            issue(1'b1, 2, 1'b1, 0);
        join
        check_order("order_running", 10'b0000100001);
        repeat (3) @(negedge clk);

        // Both requesting continuously while idle: host x4, core x1.
        grant_log.delete();
        bus.status = 2'b00;
        fork
            issue(1'b1, 8, 1'b1, 0);
            issue(1'b0, 2, 1'b1, 0);
        join
        check_order("order_idle", 10'b1111011110);
        repeat (3) @(negedge clk);

        // Status flips to running during a host access.
        grant_log.delete();
        bus.status = 2'b00;
        fork
            issue_one(1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, lat);
            begin
                int tw;
                tw = 0;
                do begin @(negedge clk); tw++; end while (!bus.mem_en && tw < 20);
                bus.status = 2'b10;
                issue_one(1'b0, 1'b1, 16'h0021, 8'h3C, 1'b0, lat_c);
            end
        join
        check("flip_host_latency", 64'(lat), 64'(2 + RD_LAT));
        check("flip_grants", {62'd0, 2'(grant_log.size())}, 64'd2);
        if (grant_log.size() == 2) check("flip_order", {62'd0, grant_log[0], grant_log[1]}, 64'b10);
        repeat (3) @(negedge clk);

        // Randomized traffic with random status changes.
        rand_done = 1'b0;
        fork
            begin
                fork
                    issue(1'b0, 40, 1'($urandom_range(0, 1)), 3);
                    issue(1'b1, 40, 1'($urandom_range(0, 1)), 3);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    if ($urandom_range(0, 7) == 0) bus.status = 2'($urandom_range(0, 2));
                end
            end
        join

        t = 0;
        while ((exp_acc.size() + exp_core.size() + exp_host.size()) != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("queues_drained", 64'(exp_acc.size() + exp_core.size() + exp_host.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
